seg_display_ctrl: RTL and testbench
===================================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter DIGITS, default 6, number of seven-segment digits driven (1..8).
REQ-002 Parameter BLINK_HALF, default 25_000_000, clock cycles per blink half-period (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  single-cycle request to capture new display contents.
REQ-006 value  input  4*DIGITS  hex nibbles; digit k = value[4k+3:4k], digit 0 least significant.
REQ-007 dp  input  DIGITS  decimal-point enable per digit, 1 = lit.
REQ-008 blink_en  input  DIGITS  per-digit blink enable.
REQ-009 lz_blank  input  1  leading-zero blanking enable.
REQ-010 busy  output  1  high while an update sequence runs.
REQ-011 HEX  output  8*DIGITS  active-low segments; digit k = HEX[8k+7:8k], bit 7 = DP, bits 6:0 = g..a.

Function
REQ-012 Glyph table (hex out, DP off) SHALL be: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 98, A 88, b 83, C C6, d A1, E 86, F 8E.
REQ-013 A DP-lit digit SHALL have bit 7 cleared; a blank digit SHALL be FF with DP off.
REQ-014 FSM states SHALL be IDLE and UPDATE only.
REQ-015 IDLE + load=1 -> capture value, dp, blink_en, lz_blank into shadow registers, set index = DIGITS-1, go UPDATE.
REQ-016 In UPDATE, one digit per cycle SHALL be decoded by a single shared decoder, index descending from DIGITS-1 to 0, into that digit's pattern register.
REQ-017 After writing index 0 the FSM SHALL return to IDLE.
REQ-018 busy SHALL equal 1 exactly while in UPDATE: load accepted at edge t gives busy=1 for edges t+1..t+DIGITS.
REQ-019 Digit k's pattern SHALL be visible on HEX on the cycle after its UPDATE write; all digits are updated DIGITS+1 cycles after load.
REQ-020 load while busy=1 SHALL be ignored; shadow registers and sequence are unaffected.
REQ-021 Inputs other than load SHALL be sampled only at capture; later changes do not affect the running sequence.
REQ-022 Leading-zero blanking applies when captured lz_blank=1, the digit nibble is 0, all higher captured nibbles are 0, and index != 0; the digit is then blank and its dp bit is ignored.
REQ-023 Digit 0 SHALL never be leading-zero blanked (all-zero value shows a single "0").
REQ-024 A 32-bit-max blink counter SHALL run freely, wrapping at BLINK_HALF-1 and toggling the blink phase on wrap.
REQ-025 While phase=1, every digit with captured blink_en set SHALL output FF; phase=0 outputs the pattern register.
REQ-026 Blink masking SHALL be registered with HEX; it SHALL not alter pattern registers or stall the FSM.
REQ-027 A digit not yet rewritten during UPDATE SHALL keep showing its previous pattern (no interim blanking).

Reset
REQ-028 rst=1 at an edge SHALL force: HEX all FF, every pattern register FF, busy 0, FSM IDLE, blink counter 0, phase 0, shadow registers 0.
REQ-029 rst SHALL take priority over load in the same cycle; no capture occurs.
REQ-030 rst mid-UPDATE SHALL abort the sequence; partially written digits are lost to FF.
REQ-031 First load after rst release SHALL be accepted on the first edge where rst=0.

Verification
REQ-032 DIGITS=6: reset, then load value=0x123456, dp=0, lz_blank=0 -> busy high 6 cycles; then HEX = F9 A4 B0 99 92 82 (digit5..digit0).
REQ-033 load value=0x00000A, lz_blank=1, dp=6'b000100 -> digits 5..1 = FF (digit 2 dp ignored), digit 0 = 88; with lz_blank=0 -> C0 C0 C0 40 C0 88.
REQ-034 load value=0, lz_blank=1 -> digits 5..1 FF, digit 0 C0.
REQ-035 BLINK_HALF=4, blink_en=6'b000001, value=0xFFFFFF -> digit 0 alternates 8E/FF every 4 cycles; digits 5..1 remain 8E.
REQ-036 Second load one cycle after first, then rst asserted on third UPDATE cycle -> second load ignored; after rst, HEX all FF, busy 0.
REQ-037 load and rst high in same cycle -> HEX stays all FF, busy stays 0.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: multi-digit seven-segment display controller.
// A load snapshots the display inputs. Then a single shared decoder refreshes
// one digit per cycle, starting at the most significant digit. The controller
// also handles leading-zero blanking, decimal points and per-digit blinking.
module seg_display_ctrl #(
  parameter int DIGITS     = 6,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic                  lz_blank,
  output logic                  busy,
  output logic [8*DIGITS-1:0]   HEX
);

  localparam int              IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]   LAST = IW'(DIGITS - 1);
  localparam logic [31:0]     WRAP = 32'(BLINK_HALF - 1);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t              state, state_nxt;
  logic                capture;

  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blink;
  logic                sh_lz;
  logic [IW-1:0]       idx;

  logic [3:0]          nib;
  logic                dp_bit;
  logic                higher_zero;
  logic                blank;
  logic [7:0]          glyph;
  logic [7:0]          dec;

  logic [7:0]          pat [DIGITS];
  logic [31:0]         blink_cnt;
  logic                phase;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept a load only when idle, stay in UPDATE until digit 0 is written
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture   = 1'b1;
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        busy = 1'b1;
        if (idx == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow registers snapshot the inputs on capture; the digit index counts down during UPDATE
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blink <= '0;
      sh_lz    <= 1'b0;
      idx      <= '0;
    end else if (capture) begin
      sh_value <= value;
      sh_dp    <= dp;
      sh_blink <= blink_en;
      sh_lz    <= lz_blank;
      idx      <= LAST;
    end else if (state == UPDATE && idx != '0) begin
      idx      <= idx - IW'(1);
    end
  end

  // Shared decoder for the digit selected by idx, including leading-zero blanking and the DP bit
  always_comb begin
    nib         = 4'h0;
    dp_bit      = 1'b0;
    higher_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib    = sh_value[4*k +: 4];
        dp_bit = sh_dp[k];
      end
      if (k > int'(idx) && sh_value[4*k +: 4] != 4'h0) higher_zero = 1'b0;
    end
    blank = sh_lz && (nib == 4'h0) && higher_zero && (idx != '0);
    case (nib)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h98;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
    dec = blank ? 8'hFF : {glyph[7] & ~dp_bit, glyph[6:0]};
  end

  // Pattern registers: only the digit under idx is rewritten, the others hold their old pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DIGITS; k++) pat[k] <= 8'hFF;
    end else if (state == UPDATE) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx == IW'(k)) pat[k] <= dec;
      end
    end
  end

  // Free-running blink timebase; the phase flips each time the counter wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == WRAP) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  // Output register: blink masking is applied here so the pattern registers are never touched
  always_ff @(posedge clk) begin
    if (rst) begin
      HEX <= '1;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        HEX[8*k +: 8] <= (phase && sh_blink[k]) ? 8'hFF : pat[k];
      end
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: scoreboard bench for seg_display_ctrl (DIGITS=6, BLINK_HALF=4).
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [23:0] value = '0;
  logic [5:0]  dp = '0;
  logic [5:0]  blink_en = '0;
  logic        lz_blank = 1'b0;
  logic        busy;
  logic [47:0] HEX;

  typedef struct {
    logic [47:0] exp;
    logic [47:0] mask;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  logic rst_q = 1'b1;
  logic prev_busy = 1'b0;
  logic armed = 1'b0;
  int   busy_run = 0;

  seg_display_ctrl #(.DIGITS(6), .BLINK_HALF(4)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp),
    .blink_en(blink_en), .lz_blank(lz_blank), .busy(busy), .HEX(HEX)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count the result
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue the display image expected when the next update sequence completes
  task automatic pushExpect(input string name, input logic [47:0] exp, input logic [47:0] mask);
    exp_t e;
    e.exp = exp;
    e.mask = mask;
    e.name = name;
    sbq.push_back(e);
  endtask

  // Issue one load pulse, starting at a falling edge and ending at the next one
  task automatic applyStimulus(input logic [23:0] v, input logic [5:0] d, input logic [5:0] b,
                               input logic lz);
    value = v;
    dp = d;
    blink_en = b;
    lz_blank = lz;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait, with a bound, until every queued expectation has been checked by the monitor
  task automatic waitDrain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got pending=%0d expected pending=0", name, sbq.size());
      sbq.delete();
    end
    checkOutput({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  // Records whether reset was applied at the last rising edge
  always @(posedge clk) rst_q <= rst;

  // Monitor: measure busy length; one cycle after busy falls (not by reset) HEX must match the queue
  always @(negedge clk) begin
    if (armed) begin
      armed = 1'b0;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_update: got HEX=%0h expected no completion", HEX);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput(e.name, 64'(HEX & e.mask), 64'(e.exp & e.mask));
      end
    end
    if (rst_q) begin
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else if (prev_busy) begin
      checkOutput("busy_len", 64'(busy_run), 64'd6);
      busy_run = 0;
      armed = 1'b1;
    end
    prev_busy = busy;
  end

  // Directed test sequence
  initial begin
    logic [7:0] d0, prev_d0;
    int run, transitions;
    logic first_seen;

    repeat (2) @(negedge clk);
    checkOutput("reset_hex", 64'(HEX), 64'hFFFF_FFFF_FFFF);
    checkOutput("reset_busy", 64'(busy), 64'd0);

    // load together with reset must not capture
    value = 24'h123456;
    load = 1'b1;
    @(negedge clk);
    checkOutput("rst_load_hex", 64'(HEX), 64'hFFFF_FFFF_FFFF);
    checkOutput("rst_load_busy", 64'(busy), 64'd0);

    // first load on the very first edge after reset release; inputs scrambled afterwards
    rst = 1'b0;
    pushExpect("digits_123456", 48'hF9A4B0999282, '1);
    applyStimulus(24'h123456, 6'b000000, 6'b000000, 1'b0);
    value = 24'hFFFFFF;
    dp = 6'b111111;
    blink_en = 6'b111111;
    lz_blank = 1'b1;
    waitDrain("digits_123456");

    // no-lz value with one DP, plus an interim check that old digits are kept
    pushExpect("no_lz_00000A", 48'hC0C0C040C088, '1);
    applyStimulus(24'h00000A, 6'b000100, 6'b000000, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("interim_hex", 64'(HEX), 64'hC0C0B0999282);
    waitDrain("no_lz_00000A");

    pushExpect("lz_00000A", 48'hFFFFFFFFFF88, '1);
    applyStimulus(24'h00000A, 6'b000100, 6'b000000, 1'b1);
    waitDrain("lz_00000A");

    pushExpect("lz_zero", 48'hFFFFFFFFFFC0, '1);
    applyStimulus(24'h000000, 6'b000000, 6'b000000, 1'b1);
    waitDrain("lz_zero");

    pushExpect("lz_00F000_dp", 48'hFFFF8EC0C040, '1);
    applyStimulus(24'h00F000, 6'b100001, 6'b000000, 1'b1);
    waitDrain("lz_00F000_dp");

    pushExpect("glyph_789ABC", 48'hF880988883C6, '1);
    applyStimulus(24'h789ABC, 6'b000000, 6'b000000, 1'b0);
    waitDrain("glyph_789ABC");

    pushExpect("glyph_DEF012", 48'hA1868EC0F9A4, '1);
    applyStimulus(24'hDEF012, 6'b000000, 6'b000000, 1'b0);
    waitDrain("glyph_DEF012");

    // second load while busy must be ignored
    pushExpect("busy_load_ignored", 48'hF9F9F9F9F9F9, '1);
    applyStimulus(24'h111111, 6'b000000, 6'b000000, 1'b0);
    value = 24'h222222;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    waitDrain("busy_load_ignored");
    repeat (10) @(negedge clk);
    checkOutput("no_second_sequence", 64'(busy), 64'd0);

    // blinking digit 0 with BLINK_HALF=4
    pushExpect("blink_upper", 48'h8E8E8E8E8E00, 48'hFFFFFFFFFF00);
    applyStimulus(24'hFFFFFF, 6'b000000, 6'b000001, 1'b0);
    waitDrain("blink_upper");
    prev_d0 = HEX[7:0];
    run = 0;
    transitions = 0;
    first_seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      d0 = HEX[7:0];
      checkOutput("blink_steady", 64'(HEX[47:8]), 64'h8E8E8E8E8E);
      checkOutput("blink_d0_value", 64'((d0 == 8'h8E) || (d0 == 8'hFF)), 64'd1);
      if (d0 != prev_d0) begin
        if (first_seen) checkOutput("blink_run", 64'(run), 64'd4);
        first_seen = 1'b1;
        transitions++;
        run = 1;
      end else begin
        run++;
      end
      prev_d0 = d0;
    end
    checkOutput("blink_toggles", 64'(transitions >= 4), 64'd1);

    // reset on the third UPDATE cycle aborts the sequence; the load during busy is ignored
    applyStimulus(24'h123456, 6'b000000, 6'b000000, 1'b0);
    value = 24'h654321;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_hex", 64'(HEX), 64'hFFFF_FFFF_FFFF);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("abort_hex_later", 64'(HEX), 64'hFFFF_FFFF_FFFF);
    checkOutput("abort_busy_later", 64'(busy), 64'd0);
    checkOutput("queue_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
